// File: rtl/bit_serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller:
// op codes, FSM states and the 1-bit slice control decode.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic       ainv;
        logic       binv;
        logic [1:0] op;
    } slice_ctrl_t;

    function automatic slice_ctrl_t slice_ctrl(
        input logic [2:0] op
    );
        slice_ctrl_t c;
        c.ainv = op[2] & ~op[1];
        c.binv = op[2];
        c.op   = {op[1], op[0] & ~op[1]};
        return c;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) ||
               (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_NOR);
    endfunction

    function automatic logic op_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/bit_serial_alu_ctrl_if.sv
// Request/result bundle between a requester and
// the bit-serial ALU controller.
interface bit_serial_alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             cout_o;
    logic             zero_o;
    logic             ovf_o;
    logic             err_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        input  busy_o, done_o, result_o,
        input  cout_o, zero_o, ovf_o, err_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        output busy_o, done_o, result_o,
        output cout_o, zero_o, ovf_o, err_o
    );
endinterface

// File: rtl/bit_serial_alu_ctrl_slice.sv
// 1-bit ALU slice: optional operand inversion,
// then AND / OR / full-adder sum selection.
module alu_slice
    import alu_ctrl_pkg::*;
(
    input  logic       i_ainv,
    input  logic       i_binv,
    input  logic       i_cin,
    input  logic [1:0] i_op,
    input  logic       i_a,
    input  logic       i_b,
    output logic       o_result,
    output logic       o_cout
);
    logic w_a;
    logic w_b;

    assign w_a = i_a ^ i_ainv;
    assign w_b = i_b ^ i_binv;

    // select the slice function and form the carry
    always_comb begin
        o_result = 1'b0;
        o_cout   = (w_a & w_b) | (w_a & i_cin) | (w_b & i_cin);
        unique case (i_op)
            2'b00:   o_result = w_a & w_b;
            2'b01:   o_result = w_a | w_b;
            2'b10:   o_result = w_a ^ w_b ^ i_cin;
            default: o_result = 1'b0;
        endcase
    end
endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU controller: one slice, LSB first,
// one bit per cycle, three-state IDLE/RUN/DONE FSM.
module bit_serial_alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    bit_serial_alu_ctrl_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_cmsb;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_done;
    logic             r_cout;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;
    slice_ctrl_t      w_ctrl;
    slice_ctrl_t      w_start_ctrl;
    logic             w_accept;
    logic             w_last;
    logic             w_res;
    logic             w_cout;
    logic             w_legal;
    logic             w_arith;

    assign w_ctrl       = slice_ctrl(r_op);
    assign w_start_ctrl = slice_ctrl(bus.op_i);
    assign w_accept     = (r_state == IDLE) & bus.start_i;
    assign w_last       = (r_idx == IW'(WIDTH - 1));
    assign w_legal      = op_legal(r_op);
    assign w_arith      = op_arith(r_op);

    alu_slice u_slice (
        .i_ainv   (w_ctrl.ainv),
        .i_binv   (w_ctrl.binv),
        .i_cin    (r_carry),
        .i_op     (w_ctrl.op),
        .i_a      (r_a[r_idx]),
        .i_b      (r_b[r_idx]),
        .o_result (w_res),
        .o_cout   (w_cout)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.start_i) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // operand latch, serial datapath and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cmsb  <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sh    <= '0;
            r_res   <= '0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_zero  <= 1'b1;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (w_accept) begin
                r_a     <= bus.a_i;
                r_b     <= bus.b_i;
                r_op    <= bus.op_i;
                r_idx   <= '0;
                r_carry <= w_start_ctrl.binv;
            end
            if (r_state == RUN) begin
                r_sh    <= {w_res, r_sh[WIDTH-1:1]};
                r_carry <= w_cout;
                if (w_last) r_cmsb <= r_carry;
                else        r_idx  <= r_idx + IW'(1);
            end
            if (r_state == DONE) begin
                r_res  <= w_legal ? r_sh : '0;
                r_zero <= w_legal ? (r_sh == '0) : 1'b1;
                r_cout <= w_arith & r_carry;
                r_ovf  <= w_arith & (r_cmsb ^ r_carry);
                r_err  <= ~w_legal;
            end
        end
    end

    assign bus.busy_o   = (r_state != IDLE);
    assign bus.done_o   = r_done;
    assign bus.result_o = r_res;
    assign bus.cout_o   = r_cout;
    assign bus.zero_o   = r_zero;
    assign bus.ovf_o    = r_ovf;
    assign bus.err_o    = r_err;
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for the bit-serial ALU controller:
// reference model results queued at issue, checked at done.
module tb_bit_serial_alu_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       zero;
        logic       ovf;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_done;
    exp_t sb[$];
    exp_t last_exp;

    bit_serial_alu_ctrl_if #(.WIDTH(8)) alu_if ();

    bit_serial_alu_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (alu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, got, exp);
    endtask

    function automatic exp_t model(
        input logic [2:0] op,
        input logic [7:0] a,
        input logic [7:0] b
    );
        exp_t       e;
        logic [8:0] s;
        e = '0;
        s = '0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b100: e.res = ~(a | b);
            3'b010: begin
                s      = {1'b0, a} + {1'b0, b};
                e.res  = s[7:0];
                e.cout = s[8];
                e.ovf  = (a[7] == b[7]) && (s[7] != a[7]);
            end
            3'b110: begin
                s      = {1'b0, a} + {1'b0, ~b} + 9'd1;
                e.res  = s[7:0];
                e.cout = s[8];
                e.ovf  = (a[7] != b[7]) && (s[7] != a[7]);
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 8'h00);
        return e;
    endfunction

    // pop and compare on every done pulse
    always @(negedge clk) begin
        if (rst_n && alu_if.done_o) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                last_exp = e;
                chk("result", alu_if.result_o, e.res);
                chk("cout", alu_if.cout_o, e.cout);
                chk("zero", alu_if.zero_o, e.zero);
                chk("ovf", alu_if.ovf_o, e.ovf);
                chk("err", alu_if.err_o, e.err);
            end
        end
    end

    task automatic scramble();
        alu_if.a_i  = 8'($urandom);
        alu_if.b_i  = 8'($urandom);
        alu_if.op_i = 3'($urandom);
    endtask

    task automatic run_op(
        input logic [2:0] op,
        input logic [7:0] a,
        input logic [7:0] b
    );
        int n;
        n = 0;
        while (alu_if.busy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        alu_if.start_i = 1'b1;
        alu_if.op_i    = op;
        alu_if.a_i     = a;
        alu_if.b_i     = b;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        alu_if.start_i = 1'b0;
        scramble();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!alu_if.done_o && n < 40);
        chk("latency", n, 10);
        @(negedge clk);
        chk("done_pulse", alu_if.done_o, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_busy"}, alu_if.busy_o, 0);
        chk({tag, "_done"}, alu_if.done_o, 0);
        chk({tag, "_res"}, alu_if.result_o, 0);
        chk({tag, "_cout"}, alu_if.cout_o, 0);
        chk({tag, "_zero"}, alu_if.zero_o, 1);
        chk({tag, "_ovf"}, alu_if.ovf_o, 0);
        chk({tag, "_err"}, alu_if.err_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] legal [5];
        int         d0;
        int         busy_gap;
        legal[0] = OP_AND;
        legal[1] = OP_OR;
        legal[2] = OP_ADD;
        legal[3] = OP_SUB;
        legal[4] = OP_NOR;
        n_chk  = 0;
        n_pass = 0;
        n_done = 0;
        rst_n  = 1'b0;
        alu_if.start_i = 1'b0;
        alu_if.op_i    = '0;
        alu_if.a_i     = '0;
        alu_if.b_i     = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_ADD, 8'h7F, 8'h01);
        run_op(OP_SUB, 8'h05, 8'h05);
        run_op(OP_SUB, 8'h80, 8'h01);
        run_op(OP_AND, 8'hF0, 8'h3C);
        run_op(OP_OR,  8'hF0, 8'h3C);
        run_op(OP_NOR, 8'hF0, 8'h3C);
        run_op(OP_ADD, 8'h80, 8'h80);
        run_op(OP_SUB, 8'h00, 8'h01);

        scramble();
        repeat (7) @(negedge clk);
        chk("hold_res", alu_if.result_o, last_exp.res);
        chk("hold_cout", alu_if.cout_o, last_exp.cout);
        chk("hold_ovf", alu_if.ovf_o, last_exp.ovf);

        run_op(3'b011, 8'hAA, 8'h55);
        run_op(3'b111, 8'h00, 8'h00);
        run_op(OP_ADD, 8'h12, 8'h34);

        for (int i = 0; i < 12; i++) begin
            logic [2:0] op;
            op = legal[$urandom_range(0, 4)];
            run_op(op, 8'($urandom), 8'($urandom));
        end

        d0       = n_done;
        busy_gap = 0;
        for (int k = 0; k < 40; k++) begin
            logic [2:0] op;
            op = legal[$urandom_range(0, 4)];
            alu_if.start_i = 1'b1;
            alu_if.op_i    = op;
            alu_if.a_i     = 8'($urandom);
            alu_if.b_i     = 8'($urandom);
            if (k % 10 == 0)
                sb.push_back(model(op, alu_if.a_i, alu_if.b_i));
            if (k > 0 && !alu_if.busy_o && !alu_if.done_o)
                busy_gap++;
            @(negedge clk);
        end
        alu_if.start_i = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_ops", n_done - d0, 4);
        chk("b2b_busy_gap", busy_gap, 0);
        chk("b2b_sb_empty", sb.size(), 0);

        alu_if.start_i = 1'b1;
        alu_if.op_i    = OP_ADD;
        alu_if.a_i     = 8'h0F;
        alu_if.b_i     = 8'h01;
        @(posedge clk);
        #1;
        alu_if.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d0    = n_done;
        rst_n = 1'b0;
        #1;
        check_reset_outs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        run_op(OP_ADD, 8'hFF, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
